quadrature_encoder_gen: RTL and testbench



---
 rtl/quadrature_encoder_gen_if.sv | 28 ++
 rtl/quadrature_encoder_gen.sv | 93 +++++++++
 tb/tb_quadrature_encoder_gen.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/quadrature_encoder_gen_if.sv
// Command/status bundle for the quadrature edge generator.
// The master side issues move commands; the slave side drives the A/B phases and status.
interface quadrature_encoder_gen_if #(
    parameter int LEN_W = 8,
    parameter int POS_W = 8
);
    logic             enable;
    logic             abort;
    logic             move_valid;
    logic             move_dir;
    logic [LEN_W-1:0] move_len;
    logic             move_ready;
    logic             quadA;
    logic             quadB;
    logic [POS_W-1:0] position;
    logic             busy;
    logic             done;

    modport master (
        output enable, abort, move_valid, move_dir, move_len,
        input  move_ready, quadA, quadB, position, busy, done
    );

    modport slave (
        input  enable, abort, move_valid, move_dir, move_len,
        output move_ready, quadA, quadB, position, busy, done
    );
endinterface

// File: rtl/quadrature_encoder_gen.sv
// Emits N Gray-stepped quadrature edges per move command, one edge every STEP_CYCLES clocks,
// tracking the same running count a downstream decoder would produce.
module quadrature_encoder_gen #(
    parameter int STEP_CYCLES = 16,
    parameter int LEN_W       = 8,
    parameter int POS_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    quadrature_encoder_gen_if.slave  bus
);
    localparam int              TMR_W  = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [TMR_W-1:0] RELOAD = TMR_W'(STEP_CYCLES - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state;
    logic             dir_q;
    logic [LEN_W-1:0] remaining;
    logic [TMR_W-1:0] timer;
    logic             qa, qb;
    logic [POS_W-1:0] pos;
    logic             done_q;
    logic             accept;
    logic             na, nb;

    // abort in IDLE swallows a simultaneous request
    assign accept = (state == S_IDLE) && bus.move_valid && !bus.abort;

    // Up walks 00->10->11->01; down walks the same ring backwards.
    assign na = dir_q ? ~qb : qb;
    assign nb = dir_q ? qa  : ~qa;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            dir_q     <= 1'b0;
            remaining <= '0;
            timer     <= '0;
            qa        <= 1'b0;
            qb        <= 1'b0;
            pos       <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (bus.move_len != '0) begin
                            dir_q     <= bus.move_dir;
                            remaining <= bus.move_len;
                            timer     <= RELOAD;
                            state     <= S_RUN;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.abort) begin
                        // abort beats a same-cycle edge: phase and count stay put
                        state     <= S_IDLE;
                        remaining <= '0;
                        timer     <= '0;
                    end else if (bus.enable) begin
                        if (timer != '0) begin
                            timer <= timer - TMR_W'(1);
                        end else begin
                            qa        <= na;
                            qb        <= nb;
                            pos       <= dir_q ? pos + POS_W'(1) : pos - POS_W'(1);
                            remaining <= remaining - LEN_W'(1);
                            timer     <= RELOAD;
                            if (remaining == LEN_W'(1)) begin
                                done_q <= 1'b1;
                                state  <= S_IDLE;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.move_ready = (state == S_IDLE);
    assign bus.busy       = (state == S_RUN);
    assign bus.quadA      = qa;
    assign bus.quadB      = qb;
    assign bus.position   = pos;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_quadrature_encoder_gen.sv
// Bench for quadrature_encoder_gen: table of move commands with a per-edge scoreboard,
// plus hand sequences for abort-in-idle, held move_valid and mid-move reset.
module tb_quadrature_encoder_gen;
    localparam int STEP = 16;

    logic clk;
    logic rst_n;

    quadrature_encoder_gen_if #(.LEN_W(8), .POS_W(8)) bus ();

    quadrature_encoder_gen #(.STEP_CYCLES(STEP), .LEN_W(8), .POS_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0] ab;
        int         pos;
        int         cyc;
    } exp_t;

    typedef struct {
        bit         dir;
        int         len;
        int         abort_n;
        int         dis_len;
        int         exp_done;
        int         exp_pos;
        logic [1:0] exp_ab;
    } vec_t;

    exp_t       sb[$];
    vec_t       vt[9];
    int         checks   = 0;
    int         errors   = 0;
    int         cyc      = 0;
    int         done_cnt = 0;
    int         done_cyc = -1;
    logic [1:0] prev_ab  = 2'b00;
    logic [1:0] seq[4];
    int         m_idx    = 0;
    int         m_pos    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Edge monitor: every change of {A,B} must match the head of the scoreboard.
    always @(negedge clk) begin : mon
        exp_t e;
        cyc++;
        if (rst_n) begin
            if ({bus.quadA, bus.quadB} != prev_ab) begin
                chk("single_phase", $countones({bus.quadA, bus.quadB} ^ prev_ab), 1);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_edge: got ab=%b pos=%0d expected no edge (cycle %0d)",
                             {bus.quadA, bus.quadB}, bus.position, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("edge_ab", int'({bus.quadA, bus.quadB}), int'(e.ab));
                    chk("edge_pos", int'(bus.position), e.pos);
                    chk("edge_cyc", cyc, e.cyc);
                end
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        prev_ab = {bus.quadA, bus.quadB};
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_step(input bit dir, output exp_t e);
        if (dir) begin
            m_idx = (m_idx + 1) % 4;
            m_pos = (m_pos + 1) % 256;
        end else begin
            m_idx = (m_idx + 3) % 4;
            m_pos = (m_pos + 255) % 256;
        end
        e.ab  = seq[m_idx];
        e.pos = m_pos;
        e.cyc = 0;
    endtask

    task automatic wait_ready(input string name);
        int bound;
        bound = 0;
        while (!bus.move_ready && bound < 2000) begin
            tick(1);
            bound++;
        end
        if (!bus.move_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: move_ready got 0 expected 1 within 2000 cycles", name);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   c0, d0, n;
        exp_t e;
        d0 = done_cnt;
        wait_ready("pre_accept");
        bus.move_valid = 1'b1;
        bus.move_dir   = v.dir;
        bus.move_len   = 8'(v.len);
        c0 = cyc;
        tick(1);
        bus.move_valid = 1'b0;
        n = (v.abort_n > 0) ? v.abort_n : v.len;
        for (int k = 1; k <= n; k++) begin
            model_step(v.dir, e);
            e.cyc = c0 + 2 + STEP * k + ((v.dis_len > 0 && k >= 2) ? v.dis_len : 0);
            sb.push_back(e);
        end
        if (v.len > 0) begin
            chk("busy_after_accept", int'(bus.busy), 1);
            chk("ready_after_accept", int'(bus.move_ready), 0);
        end
        if (v.dis_len > 0) begin
            tick(19);
            bus.enable = 1'b0;
            tick(v.dis_len);
            bus.enable = 1'b1;
        end
        if (v.abort_n > 0) begin
            tick(STEP * v.abort_n + 4);
            bus.abort = 1'b1;
            tick(1);
            bus.abort = 1'b0;
        end
        tick(2);
        wait_ready("move_end");
        tick(3);
        chk("final_pos", int'(bus.position), v.exp_pos);
        chk("final_ab", int'({bus.quadA, bus.quadB}), int'(v.exp_ab));
        chk("done_count", done_cnt - d0, v.exp_done);
        chk("sb_empty", sb.size(), 0);
        if (v.exp_done > 0)
            chk("done_cyc", done_cyc, c0 + 2 + STEP * v.len + v.dis_len);
    endtask

    initial begin : stim
        int   c0, d0;
        exp_t e;
        vec_t v;

        seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
        //          dir len abort dis done pos  ab
        vt[0] = '{1'b1, 4,  0, 0,  1,   4, 2'b00};
        vt[1] = '{1'b0, 3,  0, 0,  1,   1, 2'b10};
        vt[2] = '{1'b0, 3,  0, 0,  1, 254, 2'b11};
        vt[3] = '{1'b1, 1,  0, 0,  1, 255, 2'b01};
        vt[4] = '{1'b1, 2,  0, 0,  1,   1, 2'b10};
        vt[5] = '{1'b1, 10, 3, 0,  0,   4, 2'b00};
        vt[6] = '{1'b1, 1,  0, 0,  1,   5, 2'b10};
        vt[7] = '{1'b1, 2,  0, 40, 1,   7, 2'b01};
        vt[8] = '{1'b1, 0,  0, 0,  1,   7, 2'b01};

        rst_n          = 1'b0;
        bus.enable     = 1'b1;
        bus.abort      = 1'b0;
        bus.move_valid = 1'b0;
        bus.move_dir   = 1'b0;
        bus.move_len   = '0;
        #12;
        chk("rst_quadA", int'(bus.quadA), 0);
        chk("rst_quadB", int'(bus.quadB), 0);
        chk("rst_pos", int'(bus.position), 0);
        chk("rst_ready", int'(bus.move_ready), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        tick(3);
        rst_n = 1'b1;

        tick(100);
        chk("idle_quad", int'({bus.quadA, bus.quadB}), 0);
        chk("idle_pos", int'(bus.position), 0);
        chk("idle_ready", int'(bus.move_ready), 1);
        chk("idle_done_count", done_cnt, 0);

        foreach (vt[i]) run_vec(vt[i]);

        // abort in IDLE blocks a simultaneous request
        d0 = done_cnt;
        bus.move_valid = 1'b1;
        bus.move_dir   = 1'b1;
        bus.move_len   = 8'd3;
        bus.abort      = 1'b1;
        tick(1);
        bus.move_valid = 1'b0;
        bus.abort      = 1'b0;
        chk("abort_idle_busy", int'(bus.busy), 0);
        chk("abort_idle_ready", int'(bus.move_ready), 1);
        tick(STEP + 4);
        chk("abort_idle_done", done_cnt - d0, 0);
        chk("abort_idle_pos", int'(bus.position), 7);

        // move_valid held through RUN: second command taken only once ready returns
        d0 = done_cnt;
        bus.move_valid = 1'b1;
        bus.move_dir   = 1'b1;
        bus.move_len   = 8'd1;
        c0 = cyc;
        model_step(1'b1, e);
        e.cyc = c0 + 2 + STEP;
        sb.push_back(e);
        model_step(1'b1, e);
        e.cyc = c0 + 2 + 2 * STEP + 1;
        sb.push_back(e);
        tick(20);
        bus.move_valid = 1'b0;
        tick(2);
        wait_ready("held_valid");
        tick(3);
        chk("held_pos", int'(bus.position), 9);
        chk("held_done_count", done_cnt - d0, 2);
        chk("held_sb_empty", sb.size(), 0);

        // reset in the middle of a move returns everything to reset values
        bus.move_valid = 1'b1;
        bus.move_dir   = 1'b1;
        bus.move_len   = 8'd5;
        c0 = cyc;
        tick(1);
        bus.move_valid = 1'b0;
        model_step(1'b1, e);
        e.cyc = c0 + 2 + STEP;
        sb.push_back(e);
        tick(20);
        chk("pre_reset_pos", int'(bus.position), 10);
        chk("pre_reset_sb", sb.size(), 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_pos", int'(bus.position), 0);
        chk("midrst_quad", int'({bus.quadA, bus.quadB}), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_ready", int'(bus.move_ready), 1);
        sb.delete();
        m_idx = 0;
        m_pos = 0;
        tick(2);
        rst_n = 1'b1;
        tick(2);

        v = '{1'b1, 1, 0, 0, 1, 1, 2'b10};
        run_vec(v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
